vxe_txnid_arbiter: RTL and testbench

- Shares one memory request channel between three clients (CU, VPU0, VPU1) using round-robin arbitration.
- Builds the 6-bit transaction Id {client_id[1:0], thread_id[2:0], argument} for each granted request.
- Limits outstanding transactions per client with credit counters.
- Decodes the Id on each memory response and routes the response to the owning client.
- Sits between the VxEngine clients and the memory interface unit.

---
 rtl/vxe_txnid_arbiter.sv | 174 +++++++++++++++++
 tb/tb_vxe_txnid_arbiter.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/vxe_txnid_arbiter.sv
// Round-robin arbiter for CU/VPU0/VPU1 on one memory channel. It builds txnids, keeps per-client credits and routes responses.
// Latency: request 1 cycle after grant, response 1 cycle after arrival. Backpressure: output register holds and no grant while !i_mreq_rdy.
// Optional macro VXE_TXNID_ARB_CU_PRIO_EN: the CU gets fixed priority and VPU0/VPU1 round-robin between themselves.
module vxe_txnid_arbiter #(
    parameter int ADDR_W  = 37,
    parameter int DATA_W  = 64,
    parameter int MAX_OUT = 16
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_cu_req_vld,
    input  logic              i_vpu0_req_vld,
    input  logic              i_vpu1_req_vld,
    input  logic [ADDR_W-1:0] i_cu_req_addr,
    input  logic [ADDR_W-1:0] i_vpu0_req_addr,
    input  logic [ADDR_W-1:0] i_vpu1_req_addr,
    input  logic [2:0]        i_cu_req_thr,
    input  logic [2:0]        i_vpu0_req_thr,
    input  logic [2:0]        i_vpu1_req_thr,
    input  logic              i_cu_req_arg,
    input  logic              i_vpu0_req_arg,
    input  logic              i_vpu1_req_arg,
    output logic              o_cu_req_rdy,
    output logic              o_vpu0_req_rdy,
    output logic              o_vpu1_req_rdy,
    output logic              o_mreq_vld,
    output logic [ADDR_W-1:0] o_mreq_addr,
    output logic [5:0]        o_mreq_txnid,
    input  logic              i_mreq_rdy,
    input  logic              i_mrsp_vld,
    input  logic [5:0]        i_mrsp_txnid,
    input  logic [DATA_W-1:0] i_mrsp_data,
    output logic              o_cu_rsp_vld,
    output logic              o_vpu0_rsp_vld,
    output logic              o_vpu1_rsp_vld,
    output logic [2:0]        o_rsp_thr,
    output logic              o_rsp_arg,
    output logic [DATA_W-1:0] o_rsp_data,
    output logic              o_err
);
    logic [2:0]        w_vld, w_elig, w_gnt, w_arg, w_dec;
    logic [ADDR_W-1:0] w_addr [3];
    logic [2:0]        w_thr  [3];
    logic [4:0]        r_cnt  [3];
    logic [1:0]        r_ptr, w_gnt_id, w_rsp_cid;
    logic              w_load_ok, w_gnt_any;
    logic              r_mreq_vld, r_err;
    logic [ADDR_W-1:0] r_mreq_addr;
    logic [5:0]        r_mreq_txnid;
    logic [2:0]        r_rsp_vld, r_rsp_thr;
    logic              r_rsp_arg;
    logic [DATA_W-1:0] r_rsp_data;

    assign w_vld     = {i_vpu1_req_vld, i_vpu0_req_vld, i_cu_req_vld};
    assign w_arg     = {i_vpu1_req_arg, i_vpu0_req_arg, i_cu_req_arg};
    assign w_addr[0] = i_cu_req_addr;
    assign w_addr[1] = i_vpu0_req_addr;
    assign w_addr[2] = i_vpu1_req_addr;
    assign w_thr[0]  = i_cu_req_thr;
    assign w_thr[1]  = i_vpu0_req_thr;
    assign w_thr[2]  = i_vpu1_req_thr;
    assign w_load_ok = !r_mreq_vld || i_mreq_rdy;
    assign w_rsp_cid = i_mrsp_txnid[5:4];

    always_comb begin
        for (int c = 0; c < 3; c++) begin
            w_elig[c] = w_vld[c] && (r_cnt[c] < 5'(MAX_OUT));
            // A response to an idle client is routed but must not underflow the count.
            w_dec[c]  = i_mrsp_vld && (w_rsp_cid == 2'(c)) && (r_cnt[c] != 5'd0);
        end
    end

    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id  = 2'd0;
`ifdef VXE_TXNID_ARB_CU_PRIO_EN
        if (w_elig[0]) begin
            w_gnt_any = 1'b1;
            w_gnt_id  = 2'd0;
        end else if (w_elig[1] && (r_ptr != 2'd1 || !w_elig[2])) begin
            w_gnt_any = 1'b1;
            w_gnt_id  = 2'd1;
        end else if (w_elig[2]) begin
            w_gnt_any = 1'b1;
            w_gnt_id  = 2'd2;
        end
`else
        for (int k = 1; k <= 3; k++) begin
            logic [1:0] cand;
            cand = 2'((int'(r_ptr) + k) % 3);
            if (!w_gnt_any && w_elig[cand]) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = cand;
            end
        end
`endif
        if (!w_load_ok) begin
            w_gnt_any = 1'b0;
        end
        w_gnt = w_gnt_any ? (3'b001 << w_gnt_id) : 3'b000;
    end

    assign o_cu_req_rdy   = w_gnt[0];
    assign o_vpu0_req_rdy = w_gnt[1];
    assign o_vpu1_req_rdy = w_gnt[2];

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_ptr        <= 2'd2;
            r_mreq_vld   <= 1'b0;
            r_mreq_addr  <= '0;
            r_mreq_txnid <= '0;
            for (int c = 0; c < 3; c++) begin
                r_cnt[c] <= 5'd0;
            end
        end else begin
`ifdef VXE_TXNID_ARB_CU_PRIO_EN
            if (w_gnt_any && w_gnt_id != 2'd0) begin
                r_ptr <= w_gnt_id;
            end
`else
            if (w_gnt_any) begin
                r_ptr <= w_gnt_id;
            end
`endif
            if (w_load_ok) begin
                r_mreq_vld <= w_gnt_any;
                if (w_gnt_any) begin
                    r_mreq_addr  <= w_addr[w_gnt_id];
                    r_mreq_txnid <= {w_gnt_id, w_thr[w_gnt_id], w_arg[w_gnt_id]};
                end
            end
            for (int c = 0; c < 3; c++) begin
                r_cnt[c] <= r_cnt[c] + {4'd0, w_gnt[c]} - {4'd0, w_dec[c]};
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_rsp_vld  <= 3'b000;
            r_rsp_thr  <= 3'd0;
            r_rsp_arg  <= 1'b0;
            r_rsp_data <= '0;
            r_err      <= 1'b0;
        end else begin
            r_rsp_vld <= 3'b000;
            if (i_mrsp_vld) begin
                if (w_rsp_cid == 2'd3) begin
                    r_err <= 1'b1;
                end else begin
                    r_rsp_vld[w_rsp_cid] <= 1'b1;
                    r_rsp_thr            <= i_mrsp_txnid[3:1];
                    r_rsp_arg            <= i_mrsp_txnid[0];
                    r_rsp_data           <= i_mrsp_data;
                    if (r_cnt[w_rsp_cid] == 5'd0) begin
                        r_err <= 1'b1;
                    end
                end
            end
        end
    end

    assign o_mreq_vld     = r_mreq_vld;
    assign o_mreq_addr    = r_mreq_addr;
    assign o_mreq_txnid   = r_mreq_txnid;
    assign o_cu_rsp_vld   = r_rsp_vld[0];
    assign o_vpu0_rsp_vld = r_rsp_vld[1];
    assign o_vpu1_rsp_vld = r_rsp_vld[2];
    assign o_rsp_thr      = r_rsp_thr;
    assign o_rsp_arg      = r_rsp_arg;
    assign o_rsp_data     = r_rsp_data;
    assign o_err          = r_err;
endmodule

// File: tb/tb_vxe_txnid_arbiter.sv
// Directed bench for vxe_txnid_arbiter: grant order, stalls, credits, response routing and error flag.
module tb_vxe_txnid_arbiter;
    localparam int ADDR_W = 37;
    localparam int DATA_W = 64;

    typedef struct {
        logic [2:0] vld;
        logic [2:0] thr;
        logic       arg;
        logic       mrdy;
        logic       rvld;
        logic [5:0] rid;
        logic [2:0] e_rdy;
        logic       e_mvld;
        logic [5:0] e_tid;
        logic [2:0] e_rsp;
        logic       e_err;
    } vec_t;

    logic clk = 1'b0, nrst = 1'b0;
    logic i_cu_req_vld, i_vpu0_req_vld, i_vpu1_req_vld;
    logic [ADDR_W-1:0] i_cu_req_addr, i_vpu0_req_addr, i_vpu1_req_addr;
    logic [2:0] i_cu_req_thr, i_vpu0_req_thr, i_vpu1_req_thr;
    logic i_cu_req_arg, i_vpu0_req_arg, i_vpu1_req_arg;
    logic o_cu_req_rdy, o_vpu0_req_rdy, o_vpu1_req_rdy;
    logic o_mreq_vld, i_mreq_rdy, i_mrsp_vld;
    logic [ADDR_W-1:0] o_mreq_addr;
    logic [5:0] o_mreq_txnid, i_mrsp_txnid;
    logic [DATA_W-1:0] i_mrsp_data, o_rsp_data;
    logic o_cu_rsp_vld, o_vpu0_rsp_vld, o_vpu1_rsp_vld;
    logic [2:0] o_rsp_thr;
    logic o_rsp_arg, o_err;

    int checks = 0;
    int errors = 0;
    vec_t tab [18];

    always #5 clk = ~clk;

    vxe_txnid_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(16)) dut (
        .clk(clk), .nrst(nrst),
        .i_cu_req_vld(i_cu_req_vld), .i_vpu0_req_vld(i_vpu0_req_vld), .i_vpu1_req_vld(i_vpu1_req_vld),
        .i_cu_req_addr(i_cu_req_addr), .i_vpu0_req_addr(i_vpu0_req_addr), .i_vpu1_req_addr(i_vpu1_req_addr),
        .i_cu_req_thr(i_cu_req_thr), .i_vpu0_req_thr(i_vpu0_req_thr), .i_vpu1_req_thr(i_vpu1_req_thr),
        .i_cu_req_arg(i_cu_req_arg), .i_vpu0_req_arg(i_vpu0_req_arg), .i_vpu1_req_arg(i_vpu1_req_arg),
        .o_cu_req_rdy(o_cu_req_rdy), .o_vpu0_req_rdy(o_vpu0_req_rdy), .o_vpu1_req_rdy(o_vpu1_req_rdy),
        .o_mreq_vld(o_mreq_vld), .o_mreq_addr(o_mreq_addr), .o_mreq_txnid(o_mreq_txnid),
        .i_mreq_rdy(i_mreq_rdy), .i_mrsp_vld(i_mrsp_vld), .i_mrsp_txnid(i_mrsp_txnid),
        .i_mrsp_data(i_mrsp_data),
        .o_cu_rsp_vld(o_cu_rsp_vld), .o_vpu0_rsp_vld(o_vpu0_rsp_vld), .o_vpu1_rsp_vld(o_vpu1_rsp_vld),
        .o_rsp_thr(o_rsp_thr), .o_rsp_arg(o_rsp_arg), .o_rsp_data(o_rsp_data), .o_err(o_err)
    );

    function automatic logic [ADDR_W-1:0] caddr(input logic [1:0] c);
        return (ADDR_W'(c) + 37'd1) << 20 | 37'h0ABC;
    endfunction

    function automatic logic [DATA_W-1:0] rdata(input logic [5:0] rid);
        return 64'h0000_0000_DEAD_BEEF ^ {58'd0, rid ^ 6'h2D};
    endfunction

    function automatic vec_t mk(input logic [2:0] vld, input logic [2:0] thr, input logic arg,
                                input logic mrdy, input logic rvld, input logic [5:0] rid,
                                input logic [2:0] e_rdy, input logic e_mvld, input logic [5:0] e_tid,
                                input logic [2:0] e_rsp, input logic e_err);
        vec_t v;
        v.vld = vld; v.thr = thr; v.arg = arg; v.mrdy = mrdy; v.rvld = rvld; v.rid = rid;
        v.e_rdy = e_rdy; v.e_mvld = e_mvld; v.e_tid = e_tid; v.e_rsp = e_rsp; v.e_err = e_err;
        return v;
    endfunction

    // Expected grant order while all three clients request with free credits.
    function automatic int exp_client(input int i);
`ifdef VXE_TXNID_ARB_CU_PRIO_EN
        return (i < 16) ? 0 : 1 + ((i - 16) % 2);
`else
        return i % 3;
`endif
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input vec_t v, input string nm);
        @(negedge clk);
        i_cu_req_vld = v.vld[0]; i_vpu0_req_vld = v.vld[1]; i_vpu1_req_vld = v.vld[2];
        i_cu_req_thr = 3'd0; i_vpu0_req_thr = v.thr; i_vpu1_req_thr = v.thr;
        i_cu_req_arg = v.arg; i_vpu0_req_arg = v.arg; i_vpu1_req_arg = v.arg;
        i_mreq_rdy = v.mrdy; i_mrsp_vld = v.rvld; i_mrsp_txnid = v.rid;
        i_mrsp_data = rdata(v.rid);
        #1;
        chk({nm, ".rdy"}, 64'({o_vpu1_req_rdy, o_vpu0_req_rdy, o_cu_req_rdy}), 64'(v.e_rdy));
        @(posedge clk);
        #1;
        chk({nm, ".mvld"}, 64'(o_mreq_vld), 64'(v.e_mvld));
        if (v.e_mvld) begin
            chk({nm, ".tid"}, 64'(o_mreq_txnid), 64'(v.e_tid));
            chk({nm, ".addr"}, 64'(o_mreq_addr), 64'(caddr(v.e_tid[5:4])));
        end
        chk({nm, ".rsp"}, 64'({o_vpu1_rsp_vld, o_vpu0_rsp_vld, o_cu_rsp_vld}), 64'(v.e_rsp));
        if (v.e_rsp != 3'b000) begin
            chk({nm, ".rthr"}, 64'(o_rsp_thr), 64'(v.rid[3:1]));
            chk({nm, ".rarg"}, 64'(o_rsp_arg), 64'(v.rid[0]));
            chk({nm, ".rdat"}, o_rsp_data, rdata(v.rid));
        end
        chk({nm, ".err"}, 64'(o_err), 64'(v.e_err));
    endtask

    initial begin
        i_cu_req_addr = caddr(2'd0); i_vpu0_req_addr = caddr(2'd1); i_vpu1_req_addr = caddr(2'd2);
        i_cu_req_vld = 0; i_vpu0_req_vld = 0; i_vpu1_req_vld = 0;
        i_cu_req_thr = 0; i_vpu0_req_thr = 0; i_vpu1_req_thr = 0;
        i_cu_req_arg = 0; i_vpu0_req_arg = 0; i_vpu1_req_arg = 0;
        i_mreq_rdy = 1; i_mrsp_vld = 0; i_mrsp_txnid = 0; i_mrsp_data = 0;

        //          vld     thr   arg mrdy rvld rid    e_rdy   mvld tid    e_rsp   err
        tab[0]  = mk(3'b000, 3'd0, 0, 1, 0, 6'h00, 3'b000, 0, 6'h00, 3'b000, 0);
        tab[1]  = mk(3'b000, 3'd0, 0, 1, 1, 6'h2D, 3'b000, 0, 6'h00, 3'b100, 0);
        tab[2]  = mk(3'b000, 3'd0, 0, 1, 1, 6'h1B, 3'b000, 0, 6'h00, 3'b010, 0);
        tab[3]  = mk(3'b110, 3'd5, 1, 0, 0, 6'h00, 3'b010, 1, 6'h1B, 3'b000, 0);
        tab[4]  = mk(3'b110, 3'd5, 1, 0, 0, 6'h00, 3'b000, 1, 6'h1B, 3'b000, 0);
        tab[5]  = mk(3'b110, 3'd5, 1, 0, 0, 6'h00, 3'b000, 1, 6'h1B, 3'b000, 0);
        tab[6]  = mk(3'b110, 3'd5, 1, 0, 0, 6'h00, 3'b000, 1, 6'h1B, 3'b000, 0);
        tab[7]  = mk(3'b110, 3'd5, 1, 1, 0, 6'h00, 3'b100, 1, 6'h2B, 3'b000, 0);
        tab[8]  = mk(3'b000, 3'd0, 0, 1, 0, 6'h00, 3'b000, 0, 6'h00, 3'b000, 0);
        tab[9]  = mk(3'b001, 3'd0, 0, 1, 1, 6'h00, 3'b000, 0, 6'h00, 3'b001, 0);
        tab[10] = mk(3'b001, 3'd0, 0, 1, 0, 6'h00, 3'b001, 1, 6'h00, 3'b000, 0);
        tab[11] = mk(3'b001, 3'd0, 0, 1, 0, 6'h00, 3'b000, 0, 6'h00, 3'b000, 0);
        tab[12] = mk(3'b001, 3'd0, 0, 1, 1, 6'h00, 3'b000, 0, 6'h00, 3'b001, 0);
        tab[13] = mk(3'b001, 3'd0, 0, 1, 1, 6'h00, 3'b001, 1, 6'h00, 3'b001, 0);
        tab[14] = mk(3'b001, 3'd0, 0, 1, 0, 6'h00, 3'b001, 1, 6'h00, 3'b000, 0);
        tab[15] = mk(3'b001, 3'd0, 0, 1, 0, 6'h00, 3'b000, 0, 6'h00, 3'b000, 0);
        tab[16] = mk(3'b000, 3'd0, 0, 1, 1, 6'h30, 3'b000, 0, 6'h00, 3'b000, 1);
        tab[17] = mk(3'b000, 3'd0, 0, 1, 0, 6'h00, 3'b000, 0, 6'h00, 3'b000, 1);

        repeat (3) @(posedge clk);
        #1;
        chk("rst.mvld", 64'(o_mreq_vld), 64'd0);
        chk("rst.tid", 64'(o_mreq_txnid), 64'd0);
        chk("rst.err", 64'(o_err), 64'd0);
        @(negedge clk);
        nrst = 1'b1;
        step(mk(3'b000, 3'd0, 0, 1, 0, 6'h00, 3'b000, 0, 6'h00, 3'b000, 0), "idle");

        // All clients saturate: 48 grants, then nothing eligible and the request drops.
        for (int i = 0; i < 48; i++) begin
            int c;
            c = exp_client(i);
            step(mk(3'b111, 3'd0, 0, 1, 0, 6'h00, 3'(1 << c), 1, 6'(c << 4), 3'b000, 0),
                 $sformatf("sat%0d", i));
        end

        for (int i = 0; i < 18; i++) begin
            step(tab[i], $sformatf("v%0d", i));
        end

        // Mid-run reset clears the sticky error and every credit counter.
        @(negedge clk);
        nrst = 1'b0;
        #1;
        chk("mrst.err", 64'(o_err), 64'd0);
        chk("mrst.mvld", 64'(o_mreq_vld), 64'd0);
        chk("mrst.rsp", 64'({o_vpu1_rsp_vld, o_vpu0_rsp_vld, o_cu_rsp_vld}), 64'd0);
        @(negedge clk);
        nrst = 1'b1;

        // Response to an idle CU: routed, flagged, and the count must stay at 0 (16 more grants fit).
        step(mk(3'b000, 3'd0, 0, 1, 1, 6'h06, 3'b000, 0, 6'h00, 3'b001, 1), "uflow");
        for (int i = 0; i < 16; i++) begin
            step(mk(3'b001, 3'd0, 0, 1, 0, 6'h00, 3'b001, 1, 6'h00, 3'b000, 1), $sformatf("cu%0d", i));
        end
        step(mk(3'b001, 3'd0, 0, 1, 0, 6'h00, 3'b000, 0, 6'h00, 3'b000, 1), "cufull");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
